// File: rtl/frame_mean_divider.sv
// Frame mean divider: captures a completed frame sum and its sample count, then runs
// a one-bit-per-cycle restoring division and offers quotient/remainder on valid/ready.
module frame_mean_divider #(
    parameter int SUM_W  = 32,
    parameter int DIV_W  = 16,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SUM_W-1:0]  sum_in,
    input  logic              sum_load,
    input  logic [DIV_W-1:0]  divisor_in,
    output logic [SUM_W-1:0]  mean_out,
    output logic [DIV_W-1:0]  rem_out,
    output logic              mean_valid,
    input  logic              mean_ready,
    output logic              div_zero,
    output logic              busy,
    output logic [DROP_W-1:0] drop_count
);

    localparam int CNT_W = (SUM_W > 1) ? $clog2(SUM_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(SUM_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Division working registers; the dividend register doubles as the quotient shifter.
    logic [SUM_W-1:0]  dvd_q, dvd_d;
    logic [DIV_W-1:0]  dsr_q, dsr_d;
    logic [DIV_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  iter_q, iter_d;

    logic [SUM_W-1:0]  mean_q, mean_d;
    logic [DIV_W-1:0]  remo_q, remo_d;
    logic              valid_q, valid_d;
    logic              dz_q, dz_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              accept;
    logic              drop;
    logic              load_zero;
    logic              last_iter;
    logic [DIV_W:0]    rem_shift;
    logic [DIV_W:0]    rem_step;
    logic              sub_ok;
    logic [SUM_W-1:0]  quo_step;
    logic              rem_step_unused;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    // A load is taken in IDLE, or in HOLD on the same cycle the consumer takes the result.
    assign accept    = sum_load && ((state_q == S_IDLE) ||
                                    ((state_q == S_HOLD) && mean_ready));
    assign drop      = sum_load && !accept;
    assign load_zero = (divisor_in == '0);
    assign last_iter = (state_q == S_DIVIDE) && (iter_q == LAST_ITER);

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        rem_shift = {rem_q, dvd_q[SUM_W-1]};
        sub_ok    = (rem_shift >= {1'b0, dsr_q});
        rem_step  = sub_ok ? (rem_shift - {1'b0, dsr_q}) : rem_shift;
        quo_step  = {dvd_q[SUM_W-2:0], sub_ok};
    end

    // After a subtraction the remainder is below the divisor, so the top bit is always zero.
    assign rem_step_unused = rem_step[DIV_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sum_load) begin
                    state_d = load_zero ? S_HOLD : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (last_iter) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (mean_ready) begin
                    if (sum_load) begin
                        state_d = load_zero ? S_HOLD : S_DIVIDE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    always_comb begin
        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        rem_d  = rem_q;
        iter_d = iter_q;
        if (accept) begin
            dvd_d  = sum_in;
            dsr_d  = divisor_in;
            rem_d  = '0;
            iter_d = '0;
        end else if (state_q == S_DIVIDE) begin
            dvd_d  = quo_step;
            rem_d  = rem_step[DIV_W-1:0];
            iter_d = iter_q + CNT_W'(1);
        end
    end

    always_comb begin
        mean_d  = mean_q;
        remo_d  = remo_q;
        valid_d = valid_q;
        dz_d    = dz_q;
        drop_d  = drop ? sat_inc(drop_q) : drop_q;
        if (accept && load_zero) begin
            mean_d  = '1;
            remo_d  = '0;
            valid_d = 1'b1;
            dz_d    = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end else if (last_iter) begin
            mean_d  = quo_step;
            remo_d  = rem_step[DIV_W-1:0];
            valid_d = 1'b1;
            dz_d    = 1'b0;
        end else if ((state_q == S_HOLD) && mean_ready) begin
            valid_d = 1'b0;
        end
    end

    // Working registers need no reset: every division starts from a fresh load.
    always_ff @(posedge clk) begin
        dvd_q <= dvd_d;
        dsr_q <= dsr_d;
        rem_q <= rem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iter_q  <= '0;
            mean_q  <= '0;
            remo_q  <= '0;
            valid_q <= 1'b0;
            dz_q    <= 1'b0;
            drop_q  <= '0;
        end else begin
            iter_q  <= iter_d;
            mean_q  <= mean_d;
            remo_q  <= remo_d;
            valid_q <= valid_d;
            dz_q    <= dz_d;
            drop_q  <= drop_d;
        end
    end

    assign mean_out   = mean_q;
    assign rem_out    = remo_q;
    assign mean_valid = valid_q;
    assign div_zero   = dz_q;
    assign drop_count = drop_q;

endmodule
